// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefReadLat = 2;
  localparam int unsigned WordOffset = 2;
  localparam int unsigned CntW       = 3;

  localparam logic CauseMisaligned = 1'b1;

endpackage

// File: rtl/mem_stage_unit_data_ram.sv
// Single-port word RAM: falling-edge synchronous write, asynchronous read.
module data_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(negedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: services EX/MEM loads/stores against the data RAM and drives MEM/WB.
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned READ_LAT = DefReadLat
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p2_memRead,
  input  logic        p2_memWrite,
  input  logic [31:0] p2_adder,
  input  logic [31:0] p2_storeData,
  input  logic [31:0] p2_aluOut,
  input  logic [2:0]  p2_g1destreg,
  input  logic [2:0]  p2_rd_load,
  input  logic        p2_regWrite1,
  input  logic        p2_regWrite2,
  output logic        mem_stall,
  output logic [31:0] p3_loadData,
  output logic [31:0] p3_aluOut,
  output logic [2:0]  p3_g1destreg,
  output logic [2:0]  p3_rd_load,
  output logic        p3_regWrite1,
  output logic        p3_regWrite2,
  output logic        p3_cause,
  output logic [31:0] p3_badAddr
);

  mem_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic              misaligned;
  logic              is_store;
  logic              is_load;
  logic              ram_we;
  logic              capture;

  assign index      = p2_adder[ADDR_W+WordOffset-1:WordOffset];
  assign misaligned = (p2_memRead | p2_memWrite) & (p2_adder[WordOffset-1:0] != '0);
  assign is_store   = p2_memWrite & ~misaligned;
  // A simultaneous write wins, so the read half is dropped entirely.
  assign is_load    = p2_memRead & ~p2_memWrite & ~misaligned;

  assign ram_we   = reset & (state_q == StIdle) & is_store;
  assign ram_addr = (state_q == StWait) ? idx_q : index;

  data_ram #(
    .ADDR_W(ADDR_W)
  ) u_data_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(p2_storeData),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    mem_stall = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_load && (READ_LAT != 0)) begin
          mem_stall = 1'b1;
          state_d   = StWait;
          cnt_d     = CntW'(READ_LAT - 1);
          idx_d     = index;
        end else begin
          capture = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else begin
          capture = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      p3_loadData  <= '0;
      p3_aluOut    <= '0;
      p3_g1destreg <= '0;
      p3_rd_load   <= '0;
      p3_regWrite1 <= 1'b0;
      p3_regWrite2 <= 1'b0;
      p3_cause     <= 1'b0;
      p3_badAddr   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (capture) begin
        p3_loadData  <= is_load ? ram_rdata : '0;
        p3_aluOut    <= p2_aluOut;
        p3_g1destreg <= p2_g1destreg;
        p3_rd_load   <= p2_rd_load;
        p3_regWrite1 <= p2_regWrite1;
        p3_regWrite2 <= p2_regWrite2 & ~misaligned & ~(p2_memRead & p2_memWrite);
        p3_cause     <= misaligned ? CauseMisaligned : 1'b0;
        p3_badAddr   <= misaligned ? p2_adder : '0;
      end else begin
        // Stalled: MEM/WB takes a bubble.
        p3_regWrite1 <= 1'b0;
        p3_regWrite2 <= 1'b0;
        p3_cause     <= 1'b0;
      end
    end
  end

endmodule
